// File: rtl/iter_cell_comparator.sv
// Registered magnitude comparator built from an MSB initial cell, typical cells and an LSB final cell.
// Define ITER_CELL_PIPE_EN to add a register stage at bit WIDTH/2 (latency 2 instead of 1).
module iter_cell_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             k,
  input  logic             z,
  input  logic             l,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             res,
  output logic             valid
);

  localparam int P = WIDTH / 2;

  logic [WIDTH-1:0] x_q, y_q;
  logic             k_q, z_q, ld_q;

  // Cell outputs indexed by bit position; *_in are the inputs of cell gi.
  logic [WIDTH-1:0] sx, sy, sk;
  logic [WIDTH-2:0] sx_in, sy_in, sk_in;
  logic [WIDTH-2:0] xb, yb;
  logic             z_f;

  logic gt_q, lt_q, eq_q, res_q, valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      k_q  <= 1'b0;
      z_q  <= 1'b0;
      ld_q <= 1'b0;
    end else begin
      ld_q <= l;
      if (l) begin
        x_q <= x;
        y_q <= y;
        k_q <= k;
        z_q <= z;
      end
    end
  end

  // Initial cell: in signed mode the MSB is a sign bit, so the decision is inverted.
  assign sk[WIDTH-1] = ld_q;
  assign sx[WIDTH-1] = ld_q & (k_q ? (~x_q[WIDTH-1] & y_q[WIDTH-1])
                                   : (x_q[WIDTH-1] & ~y_q[WIDTH-1]));
  assign sy[WIDTH-1] = ld_q & (k_q ? (x_q[WIDTH-1] & ~y_q[WIDTH-1])
                                   : (~x_q[WIDTH-1] & y_q[WIDTH-1]));

`ifdef ITER_CELL_PIPE_EN
  logic           sxp_q, syp_q, skp_q, zp_q;
  logic [P-1:0]   xp_q, yp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sxp_q <= 1'b0;
      syp_q <= 1'b0;
      skp_q <= 1'b0;
      zp_q  <= 1'b0;
      xp_q  <= '0;
      yp_q  <= '0;
    end else begin
      sxp_q <= sx[P];
      syp_q <= sy[P];
      skp_q <= sk[P];
      zp_q  <= z_q;
      xp_q  <= x_q[P-1:0];
      yp_q  <= y_q[P-1:0];
    end
  end

  assign z_f = zp_q;
`else
  assign z_f = z_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_cell
`ifdef ITER_CELL_PIPE_EN
      if (gi == P - 1) begin : g_brk
        assign sx_in[gi] = sxp_q;
        assign sy_in[gi] = syp_q;
        assign sk_in[gi] = skp_q;
      end else begin : g_lnk
        assign sx_in[gi] = sx[gi+1];
        assign sy_in[gi] = sy[gi+1];
        assign sk_in[gi] = sk[gi+1];
      end
      if (gi < P) begin : g_lo
        assign xb[gi] = xp_q[gi];
        assign yb[gi] = yp_q[gi];
      end else begin : g_hi
        assign xb[gi] = x_q[gi];
        assign yb[gi] = y_q[gi];
      end
`else
      assign sx_in[gi] = sx[gi+1];
      assign sy_in[gi] = sy[gi+1];
      assign sk_in[gi] = sk[gi+1];
      assign xb[gi]    = x_q[gi];
      assign yb[gi]    = y_q[gi];
`endif
      // A decision made higher up blocks any contrary decision below it.
      assign sx[gi] = sx_in[gi] | (sk_in[gi] & ~sy_in[gi] &  xb[gi] & ~yb[gi]);
      assign sy[gi] = sy_in[gi] | (sk_in[gi] & ~sx_in[gi] & ~xb[gi] &  yb[gi]);
      assign sk[gi] = sk_in[gi];
    end
  endgenerate

  // Final stage: sk[0] marks a live load reaching the LSB; flags hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      res_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= sk[0];
      if (sk[0]) begin
        gt_q  <= sx[0];
        lt_q  <= sy[0];
        eq_q  <= ~sx[0] & ~sy[0];
        res_q <= sx[0] | (z_f & ~sx[0] & ~sy[0]);
      end
    end
  end

  assign gt    = gt_q;
  assign lt    = lt_q;
  assign eq    = eq_q;
  assign res   = res_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_iter_cell_comparator.sv
// Bench for iter_cell_comparator: 8-bit and 3-bit instances checked every cycle against an
// arithmetic reference model, plus table vectors, reset and back-to-back sequences.
module tb_iter_cell_comparator;

`ifdef ITER_CELL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] x8, y8;
  logic [2:0] x3, y3;
  logic       k, z, l;
  logic       gt8, lt8, eq8, res8, valid8;
  logic       gt3, lt3, eq3, res3, valid3;

  always #5 clk = ~clk;

  iter_cell_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .k(k), .z(z), .l(l),
    .gt(gt8), .lt(lt8), .eq(eq8), .res(res8), .valid(valid8)
  );

  iter_cell_comparator #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .x(x3), .y(y3), .k(k), .z(z), .l(l),
    .gt(gt3), .lt(lt3), .eq(eq3), .res(res3), .valid(valid3)
  );

  typedef struct {
    logic       ld;
    logic [7:0] x8, y8;
    logic [2:0] x3, y3;
    logic       k, z;
  } load_t;

  typedef struct {
    logic [7:0] x, y;
    logic       k, z;
    logic [3:0] exp;   // {gt, lt, eq, res}
  } vec_t;

  load_t      ring [4];
  int         cyc_n = 8;
  logic [3:0] held8, held3;
  int         total = 0;
  int         bad   = 0;

  // Reference: interpret operands as integers and compare arithmetically.
  function automatic logic [3:0] ref_cmp(input int xv, input int yv, input int w,
                                         input logic kv, input logic zv);
    int a, b;
    a = xv;
    b = yv;
    if (kv) begin
      if (a >= (1 << (w - 1))) a = a - (1 << w);
      if (b >= (1 << (w - 1))) b = b - (1 << w);
    end
    return {a > b, a < b, a == b, zv ? (a >= b) : (a > b)};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) ring[i].ld = 1'b0;
    held8 = 4'b0;
    held3 = 4'b0;
  endtask

  // One clock: drive at negedge, record the load at posedge, check both DUTs at next negedge.
  task automatic cyc(input logic lv, input logic [7:0] xa, input logic [7:0] ya,
                     input logic [2:0] xs, input logic [2:0] ys, input logic kv, input logic zv);
    load_t e;
    l = lv; x8 = xa; y8 = ya; x3 = xs; y3 = ys; k = kv; z = zv;
    @(posedge clk);
    cyc_n++;
    ring[cyc_n % 4] = '{lv, xa, ya, xs, ys, kv, zv};
    @(negedge clk);
    e = ring[(cyc_n - LAT) % 4];
    if (e.ld) begin
      held8 = ref_cmp(int'(e.x8), int'(e.y8), 8, e.k, e.z);
      held3 = ref_cmp(int'(e.x3), int'(e.y3), 3, e.k, e.z);
      $display("txn x8=%02h y8=%02h x3=%0d y3=%0d k=%b z=%b -> w8 gtlteqres=%b w3=%b",
               e.x8, e.y8, e.x3, e.y3, e.k, e.z, {gt8, lt8, eq8, res8}, {gt3, lt3, eq3, res3});
    end
    check("w8_flags", {valid8, gt8, lt8, eq8, res8}, {e.ld, held8});
    check("w3_flags", {valid3, gt3, lt3, eq3, res3}, {e.ld, held3});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  vec_t vt [8];

  initial begin
    vt[0] = '{8'h80, 8'h7F, 1'b0, 1'b0, 4'b1001};
    vt[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 4'b0100};
    vt[2] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 4'b1001};
    vt[3] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 4'b0010};
    vt[4] = '{8'h5A, 8'h5A, 1'b0, 1'b1, 4'b0011};
    vt[5] = '{8'h01, 8'h02, 1'b0, 1'b1, 4'b0100};
    vt[6] = '{8'h00, 8'hFF, 1'b1, 1'b1, 4'b1001};
    vt[7] = '{8'h7F, 8'h80, 1'b0, 1'b0, 4'b0100};

    rst_n = 1'b0;
    l = 1'b0; x8 = '0; y8 = '0; x3 = '0; y3 = '0; k = 1'b0; z = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check("reset_w8", {valid8, gt8, lt8, eq8, res8}, 5'b0);
    check("reset_w3", {valid3, gt3, lt3, eq3, res3}, 5'b0);
    rst_n = 1'b1;

    // Table vectors with hand-derived expectations
    foreach (vt[i]) begin
      cyc(1'b1, vt[i].x, vt[i].y, vt[i].x[2:0], vt[i].y[2:0], vt[i].k, vt[i].z);
      idle(LAT);
      check($sformatf("table%0d", i), {1'b0, gt8, lt8, eq8, res8}, {1'b0, vt[i].exp});
    end

    // Asynchronous reset mid-cycle with a load pending
    l = 1'b1; x8 = 8'h90; y8 = 8'h10; x3 = 3'd5; y3 = 3'd1; k = 1'b0; z = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_w8", {valid8, gt8, lt8, eq8, res8}, 5'b0);
    check("async_rst_w3", {valid3, gt3, lt3, eq3, res3}, 5'b0);
    @(posedge clk);
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    idle(LAT + 2);

    // Back-to-back loads
    cyc(1'b1, 8'h01, 8'h02, 3'd1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 8'h01, 3'd2, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 8'h33, 3'd3, 3'd3, 1'b0, 1'b0);
    idle(LAT + 2);
    check("b2b_hold", {1'b0, gt8, lt8, eq8, res8}, 5'b00010);

    // Exhaustive 3-bit sweep, streamed back-to-back
    for (int kv = 0; kv < 2; kv++)
      for (int zv = 0; zv < 2; zv++)
        for (int xi = 0; xi < 8; xi++)
          for (int yi = 0; yi < 8; yi++)
            cyc(1'b1, 8'($urandom), 8'($urandom), 3'(xi), 3'(yi), 1'(kv), 1'(zv));
    idle(LAT + 1);

    // Random loads with random gaps
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom),
          3'($urandom), 1'($urandom), 1'($urandom));
    idle(LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
